// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one combinational ALU between two requesters
//             (0 = execute path, 1 = branch/address path). One operation is
//             in flight at a time: IDLE accepts, EXEC lets the ALU settle on
//             registered operands, RESP presents the captured result.
//  Ports    : clk, rst (sync, active high)
//             req{0,1}_valid/ready, req{0,1}_a/_b (WIDTH), req{0,1}_ctr (CTR_W)
//             alu_busA/alu_busB/alu_ctr : registered ALU inputs
//             alu_out                   : combinational ALU result
//             rsp_valid/ready, rsp_data, rsp_zero, rsp_id : response channel
//  Config   : ALU_ARB_FIXED_PRIO_EN defined  -> requester 0 always wins
//             ALU_ARB_FIXED_PRIO_EN undefined -> round-robin on contention
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CTR_W-1:0] req0_ctr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CTR_W-1:0] req1_ctr,
    output logic [WIDTH-1:0] alu_busA,
    output logic [WIDTH-1:0] alu_busB,
    output logic [CTR_W-1:0] alu_ctr,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    logic   w_grant1;
    logic   w_idle;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 1 only wins when requester 0 is not asking.
    assign w_grant1 = req1_valid & ~req0_valid;
`else
    // Requester that was granted most recently; reset to 1 so that
    // requester 0 wins the first contention.
    logic r_last_grant;
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
`endif

    assign w_idle     = (r_state == ST_IDLE);
    assign req0_ready = w_idle & req0_valid & ~w_grant1;
    assign req1_ready = w_idle & w_grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            alu_busA  <= '0;
            alu_busB  <= '0;
            alu_ctr   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_id    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0_ready | req1_ready) begin
                        alu_busA <= w_grant1 ? req1_a   : req0_a;
                        alu_busB <= w_grant1 ? req1_b   : req0_b;
                        alu_ctr  <= w_grant1 ? req1_ctr : req0_ctr;
                        rsp_id   <= w_grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_grant1;
`endif
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Operands have been stable for a full cycle: sample result.
                    rsp_data  <= alu_out;
                    rsp_zero  <= (alu_out == '0);
                    rsp_valid <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. Provides the ALU itself,
//             a transaction-level reference model checked every cycle, and
//             directed scenarios with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_ctr, req1_ctr;
    logic [31:0] alu_busA, alu_busB, alu_out, rsp_data;
    logic [1:0]  alu_ctr;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_id;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(32), .CTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctr(req0_ctr),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctr(req1_ctr),
        .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_ctr(alu_ctr),
        .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_id(rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] c);
        case (c)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a | b;
            default: return 32'd0;
        endcase
    endfunction

    // The ALU the arbiter drives.
    assign alu_out = alu_ref(alu_busA, alu_busB, alu_ctr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_init = 0;
    bit          m_busy;        // an operation accepted and not yet returned
    int          m_age;         // cycles since accept (1 = ALU settling, 2 = response up)
    bit          m_last;
    logic [31:0] m_a, m_b, m_data;
    logic [1:0]  m_ctr;
    bit          m_id;
    bit          e0, e1;

    function automatic bit grant0();
`ifdef ALU_ARB_FIXED_PRIO_EN
        return req0_valid;
`else
        return req0_valid && (!req1_valid || m_last);
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_busy = 0; m_age = 0; m_last = 1;
            m_a = 0; m_b = 0; m_ctr = 0; m_data = 0; m_id = 0;
        end else if (m_init) begin
            if (m_busy) begin
                if (m_age == 1) begin
                    m_data = alu_ref(m_a, m_b, m_ctr);
                    m_age  = 2;
                end else if (rsp_ready) begin
                    m_busy = 0;
                end
            end else if (grant0() || req1_valid) begin
                m_id   = !grant0();
                m_last = m_id;
                m_a    = m_id ? req1_a   : req0_a;
                m_b    = m_id ? req1_b   : req0_b;
                m_ctr  = m_id ? req1_ctr : req0_ctr;
                m_busy = 1;
                m_age  = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            e0 = !m_busy && grant0();
            e1 = !m_busy && req1_valid && !grant0();
            chk("model_req0_ready", {31'd0, req0_ready}, {31'd0, e0});
            chk("model_req1_ready", {31'd0, req1_ready}, {31'd0, e1});
            chk("model_alu_busA", alu_busA, m_a);
            chk("model_alu_busB", alu_busB, m_b);
            chk("model_alu_ctr", {30'd0, alu_ctr}, {30'd0, m_ctr});
            chk("model_rsp_valid", {31'd0, rsp_valid}, {31'd0, (m_busy && m_age == 2)});
            if (m_busy && m_age == 2) begin
                chk("model_rsp_data", rsp_data, m_data);
                chk("model_rsp_zero", {31'd0, rsp_zero}, {31'd0, (m_data == 32'd0)});
                chk("model_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] c);
        bit got = 0;
        if (id) begin req1_a = a; req1_b = b; req1_ctr = c; req1_valid = 1; end
        else    begin req0_a = a; req0_b = b; req0_ctr = c; req0_valid = 1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin got = 1; break; end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got no ready for requester %0d expected ready", id);
        end
        @(posedge clk); #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic z, output logic id,
                           output int n);
        n = 0; d = 0; z = 0; id = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin n = i; break; end
        end
        if (n == 0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: got no rsp_valid expected response");
        end else begin
            d = rsp_data; z = rsp_zero; id = rsp_id;
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] d;
    logic        z, rid;
    int          n;
    logic        order[4];
    logic        exp_order[4];

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`else
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`endif
        rst = 1; rsp_ready = 1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctr = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_busA", alu_busA, 32'd0);
        chk("reset_busB", alu_busB, 32'd0);
        chk("reset_ctr", {30'd0, alu_ctr}, 32'd0);
        chk("reset_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("reset_rsp_fields", {rsp_data[29:0], rsp_zero, rsp_id}, 32'd0);
        @(posedge clk); #1;

        // Single op: 5 - 3
        issue(0, 32'd5, 32'd3, 2'b01);
        chk("single_busA", alu_busA, 32'd5);
        chk("single_busB", alu_busB, 32'd3);
        chk("single_ctr", {30'd0, alu_ctr}, 32'd1);
        get_rsp(d, z, rid, n);
        chk("single_latency", n, 32'd2);
        chk("single_data", d, 32'd2);
        chk("single_zero", {31'd0, z}, 32'd0);
        chk("single_id", {31'd0, rid}, 32'd0);

        // Zero / undefined / wrap / OR
        issue(1, 32'd7, 32'd7, 2'b01);
        get_rsp(d, z, rid, n);
        chk("sub_zero_data", d, 32'd0);
        chk("sub_zero_flag", {31'd0, z}, 32'd1);
        chk("sub_zero_id", {31'd0, rid}, 32'd1);
        issue(0, 32'd9, 32'd4, 2'b11);
        get_rsp(d, z, rid, n);
        chk("undef_data", d, 32'd0);
        chk("undef_zero", {31'd0, z}, 32'd1);
        issue(0, 32'hFFFF_FFFF, 32'd1, 2'b00);
        get_rsp(d, z, rid, n);
        chk("wrap_data", d, 32'd0);
        chk("wrap_zero", {31'd0, z}, 32'd1);
        issue(1, 32'h0000_00F0, 32'h0000_000F, 2'b10);
        get_rsp(d, z, rid, n);
        chk("or_data", d, 32'h0000_00FF);
        chk("or_zero", {31'd0, z}, 32'd0);

        // Contention from a fresh reset
        rst = 1; @(posedge clk); #1 rst = 0;
        req0_a = 1; req0_b = 1; req0_ctr = 0; req0_valid = 1;
        req1_a = 1; req1_b = 1; req1_ctr = 0; req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            get_rsp(d, z, rid, n);
            order[k] = rid;
            chk("contend_data", d, 32'd2);
            if (k == 3) begin req0_valid = 0; req1_valid = 0; end
        end
        for (int k = 0; k < 4; k++) chk("contend_order", {31'd0, order[k]}, {31'd0, exp_order[k]});

        // Back-pressure
        @(posedge clk); #1;
        rsp_ready = 0;
        issue(0, 32'd10, 32'd20, 2'b00);
        req1_a = 2; req1_b = 3; req1_ctr = 2'b01; req1_valid = 1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin n = i; break; end
        end
        chk("bp_rsp_arrives", {31'd0, (n != 0)}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data_held", rsp_data, 32'd30);
            chk("bp_id_held", {31'd0, rsp_id}, 32'd0);
            chk("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        chk("bp_last_resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_no_early_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_accept_next", {31'd0, req1_ready}, 32'd1);
        chk("bp_valid_fell", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1 req1_valid = 0;
        get_rsp(d, z, rid, n);
        chk("bp_next_data", d, 32'hFFFF_FFFF);
        chk("bp_next_id", {31'd0, rid}, 32'd1);

        // Reset during EXEC
        issue(0, 32'd1, 32'd2, 2'b00);
        rst = 1; @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        chk("midrst_busA", alu_busA, 32'd0);
        @(posedge clk); #1;
        issue(1, 32'd4, 32'd5, 2'b00);
        get_rsp(d, z, rid, n);
        chk("midrst_next_data", d, 32'd9);
        chk("midrst_next_id", {31'd0, rid}, 32'd1);
        chk("midrst_next_latency", n, 32'd2);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
